// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster timing source (default 640x480 @ 60 Hz, 800x525 total).
// Latency: every output is a register; flags are decoded from the next count so
//          they line up with pixel_x/pixel_y on the same cycle (zero relative latency).
// Backpressure: none; free-running raster, advancing once per pixel tick.
//
// Ports:
//   clk_d        display clock
//   rst          synchronous, active-high reset
//   pixel_x      horizontal count, 0..H_TOTAL-1
//   pixel_y      vertical count, 0..V_TOTAL-1
//   video_on     high inside the visible window
//   hsync/vsync  active-low sync strobes
//   p_tick       one-cycle pixel enable (last clk_d cycle of the current pixel)
//   frame_start  one-cycle pulse when the raster wraps to (0,0)
//   frame_cnt    16-bit frame counter, present only when VGA_SYNC_FRAME_CNT_EN is defined
//
// Optional feature macro: VGA_SYNC_FRAME_CNT_EN

module vga_sync_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int TICK_DIV  = 1
) (
  input  logic       clk_d,
  input  logic       rst,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       p_tick,
  output logic       frame_start
`ifdef VGA_SYNC_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  // Parameter legality is checked once, at elaboration.
  if ((H_TOTAL > 1023) || (V_TOTAL > 1023) || (TICK_DIV < 1) || (TICK_DIV > 16) ||
      (H_DISPLAY < 1) || (V_DISPLAY < 1) || (H_SYNC < 1) || (V_SYNC < 1)) begin : g_bad_params
    $error("vga_sync_gen: illegal timing parameters");
  end

  localparam logic [9:0] H_MAX      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX      = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_DISP     = 10'(H_DISPLAY);
  localparam logic [9:0] V_DISP     = 10'(V_DISPLAY);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] H_SYNC_END = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] V_SYNC_END = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic [3:0] DIV_MAX    = 4'(TICK_DIV - 1);

  logic [3:0] r_div_cnt;
  logic [9:0] r_pixel_x;
  logic [9:0] r_pixel_y;
  logic       r_video_on;
  logic       r_hsync;
  logic       r_vsync;
  logic       r_p_tick;
  logic       r_frame_start;

  logic       w_tick;
  logic [3:0] w_div_nxt;
  logic       w_x_wrap;
  logic       w_y_wrap;
  logic [9:0] w_x_nxt;
  logic [9:0] w_y_nxt;

  assign w_tick    = (r_div_cnt == DIV_MAX);
  assign w_div_nxt = w_tick ? 4'd0 : (r_div_cnt + 4'd1);

  assign w_x_wrap  = (r_pixel_x == H_MAX);
  assign w_y_wrap  = (r_pixel_y == V_MAX);
  assign w_x_nxt   = w_x_wrap ? 10'd0 : (r_pixel_x + 10'd1);
  assign w_y_nxt   = w_x_wrap ? (w_y_wrap ? 10'd0 : (r_pixel_y + 10'd1)) : r_pixel_y;

  always_ff @(posedge clk_d) begin
    if (rst) begin
      r_div_cnt     <= 4'd0;
      r_pixel_x     <= 10'd0;
      r_pixel_y     <= 10'd0;
      r_video_on    <= 1'b0;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_p_tick      <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_div_cnt     <= w_div_nxt;
      // p_tick is loaded from the next divider value so the registered strobe
      // coincides with the cycle in which the counters are about to advance.
      r_p_tick      <= (w_div_nxt == DIV_MAX);
      r_frame_start <= w_tick && w_x_wrap && w_y_wrap;
      if (w_tick) begin
        r_pixel_x  <= w_x_nxt;
        r_pixel_y  <= w_y_nxt;
        // Flags decoded from the next counts land together with those counts.
        // Because they only move on a tick, (0,0) right after reset stays blanked.
        r_video_on <= (w_x_nxt < H_DISP) && (w_y_nxt < V_DISP);
        r_hsync    <= !((w_x_nxt >= H_SYNC_BEG) && (w_x_nxt <= H_SYNC_END));
        r_vsync    <= !((w_y_nxt >= V_SYNC_BEG) && (w_y_nxt <= V_SYNC_END));
      end
    end
  end

  assign pixel_x     = r_pixel_x;
  assign pixel_y     = r_pixel_y;
  assign video_on    = r_video_on;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign p_tick      = r_p_tick;
  assign frame_start = r_frame_start;

`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  // Steps on the same edge that raises frame_start; wraps naturally at 16 bits.
  always_ff @(posedge clk_d) begin
    if (rst) begin
      r_frame_cnt <= 16'd0;
    end else if (w_tick && w_x_wrap && w_y_wrap) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`endif

endmodule
